dm_cache_ctrl: RTL and testbench
================================

Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller between a single CPU requester and the single-port block memory (2 words per block).
- Holds tag, valid and data arrays for NUM_LINES lines.
- Serves read hits locally. Sequences `read_en`/`write_en` pulses to the memory for line fills and write-throughs.
- Keeps hit/miss statistics.

Parameters:
- DATA_WIDTH, 32, CPU and memory word width.
- ADDR_WIDTH, 12, CPU word address width: {tag, index, offset}.
- NUM_LINES, 16, cache lines, power of 2; INDEX_BITS = $clog2(NUM_LINES).
- MEM_LAT, 2, cycles from a memory strobe cycle to the earliest cycle `data_out` is valid / the memory is idle again.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- cpu_req  input  1  request strobe, sampled only while cpu_ready=1
- cpu_we  input  1  1=write, 0=read
- cpu_addr  input  ADDR_WIDTH  word address; bit 0 is the word offset
- cpu_wdata  input  DATA_WIDTH  write data
- cpu_ready  output  1  controller idle, request accepted this cycle
- cpu_valid  output  1  one-cycle completion pulse (read data or write ack)
- cpu_rdata  output  DATA_WIDTH  read data, valid when cpu_valid=1 and the request was a read
- mem_read_en  output  1  memory read strobe
- mem_write_en  output  1  memory write strobe
- mem_block_addr  output  ADDR_WIDTH-1  memory block address = cpu_addr[ADDR_WIDTH-1:1]
- mem_word_offset  output  1  memory word offset
- mem_data_in  output  DATA_WIDTH  memory write data
- mem_data_out  input  DATA_WIDTH  memory read data
- hit_count  output  16  saturating read-hit count
- miss_count  output  16  saturating read-miss count

Behaviour:
- Address split:
  - offset = cpu_addr[0]
  - index = cpu_addr[INDEX_BITS:1]
  - tag = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+1]
- Request capture:
  - A request is captured into internal registers when cpu_req=1 and cpu_ready=1.
  - cpu_addr, cpu_we and cpu_wdata are don't-care afterwards.
- cpu_ready = (state==IDLE).
- Reset values:
  - All valid bits 0.
  - cpu_valid=0, cpu_rdata=0, mem_read_en=0, mem_write_en=0, mem addresses and data 0.
  - Counters 0, state IDLE, so cpu_ready=1.
  - Data and tag arrays are not reset.
- FSM states: IDLE, RESP, FILL0, WAIT0, FILL1, WAIT1, WT, WT_WAIT.
- IDLE, request accepted:
  - Read hit (valid[index] && tag match): go to RESP. In RESP, cpu_valid=1 and cpu_rdata = the line word, one cycle after acceptance. hit_count+1. Then IDLE.
  - Read miss: go to FILL0. miss_count+1.
  - Write, hit or miss: go to WT. On a hit, update the cached word in the acceptance cycle. On a miss, leave the cache untouched.
- FILL0:
  - mem_read_en=1 for exactly one cycle; word_offset=0, block_addr = captured {tag,index}.
  - Go to WAIT0.
- WAIT0:
  - Count MEM_LAT cycles, then capture mem_data_out as word 0.
  - Go to FILL1.
- FILL1 / WAIT1: same as FILL0 / WAIT0 with word_offset=1.
  - At the end of WAIT1, write both words, the tag and valid=1 into the line.
  - Drive cpu_valid=1 with the requested word on that same cycle, then IDLE.
- WT:
  - mem_write_en=1 for one cycle, with mem_data_in = captured wdata and the captured offset/block address.
  - Go to WT_WAIT.
- WT_WAIT:
  - Wait MEM_LAT cycles.
  - Pulse cpu_valid=1 as the write ack (cpu_rdata unchanged), then IDLE.
- Memory strobe rules:
  - Strobes are never held high for more than one cycle.
  - mem_read_en and mem_write_en are never both 1.
  - No new strobe is issued before MEM_LAT cycles have elapsed since the last one.
- Latencies with MEM_LAT=2:
  - Read hit: 1 cycle.
  - Read miss: 2×(1+MEM_LAT) = 6 cycles from acceptance to cpu_valid.
  - Write: 1+MEM_LAT = 3 cycles.
- Counters saturate at 16'hFFFF.
- Back-to-back: cpu_req held high is re-accepted on the first cycle cpu_ready returns to 1.
- Conflict miss: a miss replaces the line at that index unconditionally. No writeback is needed because the cache is write-through.
- Reset mid-operation:
  - The FSM aborts to IDLE and all valid bits clear immediately (asynchronously).
  - Strobes drop in the same cycle.
  - No cpu_valid is issued for the aborted request.

Test Plan:
- After reset, read addr 0x010 with memory preloaded block 0x008 = {0xAAAA0000, 0xBBBB1111} -> exactly two mem_read_en pulses (offsets 0 then 1); cpu_valid 6 cycles after acceptance with cpu_rdata=0xAAAA0000; miss_count=1.
- Then read addr 0x011 -> cpu_valid next cycle, cpu_rdata=0xBBBB1111, no memory strobe, hit_count=1.
- Write 0x11223344 to 0x010 (hit) -> one mem_write_en with block_addr=0x008 and offset 0; ack after 3 cycles; subsequent read of 0x010 hits and returns 0x11223344.
- Write to uncached 0x400, then read 0x400 -> write does not allocate; the read misses, fills from memory and returns the written value.
- Conflict: read 0x010, then 0x030 (same index, different tag), then 0x010 -> misses=3, hits=0; each miss issues two fill strobes.
- Assert rst low during WAIT0 of a miss -> strobes 0, cpu_ready=1 after release; the same read misses again; no spurious cpu_valid.

Source files
------------

// File: rtl/dm_cache_ctrl_if.sv
// Signal bundle joining the CPU requester, the cache controller and the block memory.
// The controller takes the slave view; the requester/memory environment takes the master view.
interface dm_cache_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_ready;
  logic                  cpu_valid;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  mem_read_en;
  logic                  mem_write_en;
  logic [ADDR_WIDTH-2:0] mem_block_addr;
  logic                  mem_word_offset;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_data_out,
    output cpu_ready, cpu_valid, cpu_rdata,
    output mem_read_en, mem_write_en, mem_block_addr, mem_word_offset, mem_data_in
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_data_out,
    input  cpu_ready, cpu_valid, cpu_rdata,
    input  mem_read_en, mem_write_en, mem_block_addr, mem_word_offset, mem_data_in
  );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with two-word blocks.
// Read hits are served locally; fills and write-throughs are sequenced as single-cycle memory strobes.
module dm_cache_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_LINES  = 16,
  parameter int MEM_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  dm_cache_ctrl_if.slave bus,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 1;
  localparam int CNT_W      = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, RESP, FILL0, WAIT0, FILL1, WAIT1, WT, WT_WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] word0_q, word0_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [15:0]           hit_q, hit_d;
  logic [15:0]           miss_q, miss_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;

  logic [TAG_BITS-1:0]   tag_arr  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_arr [NUM_LINES][2];

  logic                  in_off, cap_off;
  logic [INDEX_BITS-1:0] in_idx, cap_idx;
  logic [TAG_BITS-1:0]   in_tag, cap_tag;
  logic                  in_hit;
  logic                  cnt_done;
  logic [DATA_WIDTH-1:0] fill_word;
  logic                  cpu_valid_o, rd_en, wr_en, word_off;
  logic                  wr_hit_en, fill_en;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign in_off   = bus.cpu_addr[0];
  assign in_idx   = bus.cpu_addr[INDEX_BITS:1];
  assign in_tag   = bus.cpu_addr[ADDR_WIDTH-1:INDEX_BITS+1];
  assign cap_off  = addr_q[0];
  assign cap_idx  = addr_q[INDEX_BITS:1];
  assign cap_tag  = addr_q[ADDR_WIDTH-1:INDEX_BITS+1];
  assign in_hit   = valid_q[in_idx] && (tag_arr[in_idx] == in_tag);
  assign cnt_done = (cnt_q == CNT_LAST);
  // Word 1 arrives on the completion cycle itself, so the requested word bypasses the line.
  assign fill_word = cap_off ? bus.mem_data_out : word0_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    word0_d     = word0_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    valid_d     = valid_q;
    cpu_valid_o = 1'b0;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    word_off    = cap_off;
    wr_hit_en   = 1'b0;
    fill_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          if (bus.cpu_we) begin
            wr_hit_en = in_hit;
            state_d   = WT;
          end else if (in_hit) begin
            rdata_d = data_arr[in_idx][in_off];
            hit_d   = sat_inc(hit_q);
            state_d = RESP;
          end else begin
            miss_d  = sat_inc(miss_q);
            state_d = FILL0;
          end
        end
      end
      RESP: begin
        cpu_valid_o = 1'b1;
        state_d     = IDLE;
      end
      FILL0: begin
        rd_en    = 1'b1;
        word_off = 1'b0;
        cnt_d    = '0;
        state_d  = WAIT0;
      end
      WAIT0: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_done) begin
          word0_d = bus.mem_data_out;
          state_d = FILL1;
        end
      end
      FILL1: begin
        rd_en    = 1'b1;
        word_off = 1'b1;
        cnt_d    = '0;
        state_d  = WAIT1;
      end
      WAIT1: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_done) begin
          fill_en          = 1'b1;
          valid_d[cap_idx] = 1'b1;
          rdata_d          = fill_word;
          cpu_valid_o      = 1'b1;
          state_d          = IDLE;
        end
      end
      WT: begin
        wr_en   = 1'b1;
        cnt_d   = '0;
        state_d = WT_WAIT;
      end
      WT_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_done) begin
          cpu_valid_o = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      word0_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word0_q <= word0_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data storage carry no reset; the valid bits alone decide what is usable.
  always_ff @(posedge clk) begin
    if (wr_hit_en) begin
      data_arr[in_idx][in_off] <= bus.cpu_wdata;
    end
    if (fill_en) begin
      tag_arr[cap_idx]     <= cap_tag;
      data_arr[cap_idx][0] <= word0_q;
      data_arr[cap_idx][1] <= bus.mem_data_out;
    end
  end

  assign bus.cpu_ready       = (state_q == IDLE);
  assign bus.cpu_valid       = cpu_valid_o;
  assign bus.cpu_rdata       = fill_en ? fill_word : rdata_q;
  assign bus.mem_read_en     = rd_en;
  assign bus.mem_write_en    = wr_en;
  assign bus.mem_block_addr  = addr_q[ADDR_WIDTH-1:1];
  assign bus.mem_word_offset = word_off;
  assign bus.mem_data_in     = wdata_q;
  assign hit_count           = hit_q;
  assign miss_count          = miss_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: a timed block memory, a strobe recorder and a per-request cache model.
module tb_dm_cache_ctrl;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NL = 16;
  localparam int ML = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] hit_count, miss_count;

  always #5 clk = ~clk;

  dm_cache_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dm_cache_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LINES(NL), .MEM_LAT(ML)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
  );

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    bit            is_wr;
    logic [AW-2:0] blk;
    logic          off;
    logic [DW-1:0] data;
  } strobe_t;

  logic [DW-1:0] mem [0:4095];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  strobe_t       strobes[$];
  int            strobe_viol = 0;

  // Reference state: what the cache should hold, what memory holds, counters and last read data.
  bit            ref_valid [NL];
  logic [6:0]    ref_tag   [NL];
  logic [DW-1:0] ref_data  [NL][2];
  logic [DW-1:0] ref_mem   [4096];
  logic [15:0]   ref_hits, ref_misses;
  logic [DW-1:0] ref_rdata;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Memory: read data appears MEM_LAT cycles after the strobe cycle, garbage before that.
  initial begin : mem_model
    int cyc;
    int last;
    int rd_wait;
    logic [AW-1:0] rd_addr;
    strobe_t s;
    cyc = 0; last = -100; rd_wait = 0; rd_addr = '0;
    bus.mem_data_out = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (pre_we === 1'b1) mem[pre_addr] = pre_data;
      if (rd_wait > 0) begin
        rd_wait--;
        if (rd_wait == 0) bus.mem_data_out = mem[rd_addr];
      end
      if (bus.mem_read_en === 1'b1 || bus.mem_write_en === 1'b1) begin
        if (bus.mem_read_en === 1'b1 && bus.mem_write_en === 1'b1) strobe_viol++;
        if (cyc - last <= ML) strobe_viol++;
        last = cyc;
        s.is_wr = (bus.mem_write_en === 1'b1);
        s.blk = bus.mem_block_addr;
        s.off = bus.mem_word_offset;
        s.data = bus.mem_data_in;
        strobes.push_back(s);
        if (s.is_wr) begin
          mem[{s.blk, s.off}] = s.data;
        end else begin
          rd_addr = {s.blk, s.off};
          rd_wait = ML;
          bus.mem_data_out = $urandom;
        end
      end
    end
  end

  task automatic ref_clear();
    foreach (ref_valid[i]) ref_valid[i] = 1'b0;
    ref_hits = '0;
    ref_misses = '0;
    ref_rdata = '0;
  endtask

  task automatic preload_all();
    pre_we = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      pre_addr = 12'(i);
      pre_data = $urandom;
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ref_clear();
    @(negedge clk);
  endtask

  // One request end to end; expectations come from the reference state before it is updated.
  task automatic do_op(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int n0, lat, exp_lat, exp_n;
    bit got, hit;
    logic [3:0] idx;
    logic [6:0] tg;
    logic off;
    logic [DW-1:0] exp_rd, act_rd;
    idx = addr[4:1]; tg = addr[11:5]; off = addr[0];
    hit = ref_valid[idx] && (ref_tag[idx] == tg);
    n0 = strobes.size();
    compared++;
    if (bus.cpu_ready !== 1'b1) begin
      mismatched++; $display("FAIL ready_before_op addr=%h: got %b want 1", addr, bus.cpu_ready);
    end
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'($urandom); bus.cpu_addr = 12'($urandom); bus.cpu_wdata = $urandom;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.cpu_valid === 1'b1) got = 1'b1;
    end
    act_rd = bus.cpu_rdata;
    if (we) begin
      exp_lat = 1 + ML; exp_n = 1;
      ref_mem[addr] = wd;
      if (hit) ref_data[idx][off] = wd;
      exp_rd = ref_rdata;
    end else if (hit) begin
      exp_lat = 1; exp_n = 0;
      exp_rd = ref_data[idx][off];
      ref_hits = sat_inc(ref_hits);
    end else begin
      exp_lat = 2 * (1 + ML); exp_n = 2;
      ref_valid[idx] = 1'b1; ref_tag[idx] = tg;
      ref_data[idx][0] = ref_mem[{addr[11:1], 1'b0}];
      ref_data[idx][1] = ref_mem[{addr[11:1], 1'b1}];
      exp_rd = ref_data[idx][off];
      ref_misses = sat_inc(ref_misses);
    end
    ref_rdata = exp_rd;
    compared++;
    if (!got || lat != exp_lat) begin
      mismatched++; $display("FAIL latency addr=%h we=%0d: got %0d (valid seen=%0d) want %0d", addr, we, lat, got, exp_lat);
    end
    compared++;
    if (act_rd !== exp_rd) begin
      mismatched++; $display("FAIL rdata addr=%h we=%0d: got %h want %h", addr, we, act_rd, exp_rd);
    end
    compared++;
    if (strobes.size() - n0 != exp_n) begin
      mismatched++; $display("FAIL strobe_count addr=%h we=%0d: got %0d want %0d", addr, we, strobes.size() - n0, exp_n);
    end else begin
      for (int k = 0; k < exp_n; k++) begin
        strobe_t s;
        logic exp_off;
        s = strobes[n0 + k];
        exp_off = we ? off : k[0];
        compared++;
        if (s.is_wr !== we || s.blk !== addr[11:1] || s.off !== exp_off || (we && s.data !== wd)) begin
          mismatched++;
          $display("FAIL strobe%0d addr=%h: got wr=%0d blk=%h off=%b data=%h want wr=%0d blk=%h off=%b data=%h",
                   k, addr, s.is_wr, s.blk, s.off, s.data, we, addr[11:1], exp_off, wd);
        end
      end
    end
    @(negedge clk);
    compared++;
    if (bus.cpu_valid !== 1'b0) begin
      mismatched++; $display("FAIL valid_pulse_width addr=%h: got %b want 0", addr, bus.cpu_valid);
    end
    compared++;
    if (hit_count !== ref_hits || miss_count !== ref_misses) begin
      mismatched++; $display("FAIL counters addr=%h: got hit=%0d miss=%0d want hit=%0d miss=%0d", addr, hit_count, miss_count, ref_hits, ref_misses);
    end
    compared++;
    if (strobe_viol != 0) begin
      mismatched++; $display("FAIL strobe_rules: got %0d violations want 0", strobe_viol);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    compared++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_valid !== 1'b0) begin
      mismatched++; $display("FAIL reset_handshake: got ready=%b valid=%b want 1/0", bus.cpu_ready, bus.cpu_valid);
    end
    compared++;
    if (bus.cpu_rdata !== '0) begin
      mismatched++; $display("FAIL reset_rdata: got %h want 0", bus.cpu_rdata);
    end
    compared++;
    if (bus.mem_read_en !== 1'b0 || bus.mem_write_en !== 1'b0) begin
      mismatched++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0/0", bus.mem_read_en, bus.mem_write_en);
    end
    compared++;
    if (bus.mem_block_addr !== '0 || bus.mem_word_offset !== 1'b0 || bus.mem_data_in !== '0) begin
      mismatched++; $display("FAIL reset_mem_bus: got blk=%h off=%b din=%h want 0", bus.mem_block_addr, bus.mem_word_offset, bus.mem_data_in);
    end
    compared++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      mismatched++; $display("FAIL reset_counters: got hit=%0d miss=%0d want 0/0", hit_count, miss_count);
    end
    rst = 1'b1;
    ref_clear();
    @(negedge clk);
  endtask

  task automatic test_read_miss();
    preload(12'h010, 32'hAAAA0000);
    preload(12'h011, 32'hBBBB1111);
    do_op(1'b0, 12'h010, '0);
    compared++;
    if (bus.cpu_rdata !== 32'hAAAA0000 || miss_count !== 16'd1) begin
      mismatched++; $display("FAIL read_miss_plan: got rdata=%h miss=%0d want aaaa0000/1", bus.cpu_rdata, miss_count);
    end
  endtask

  task automatic test_read_hit();
    do_op(1'b0, 12'h011, '0);
    compared++;
    if (bus.cpu_rdata !== 32'hBBBB1111 || hit_count !== 16'd1) begin
      mismatched++; $display("FAIL read_hit_plan: got rdata=%h hit=%0d want bbbb1111/1", bus.cpu_rdata, hit_count);
    end
  endtask

  task automatic test_write_hit();
    do_op(1'b1, 12'h010, 32'h11223344);
    do_op(1'b0, 12'h010, '0);
    compared++;
    if (bus.cpu_rdata !== 32'h11223344) begin
      mismatched++; $display("FAIL write_hit_readback: got %h want 11223344", bus.cpu_rdata);
    end
  endtask

  task automatic test_write_no_allocate();
    logic [15:0] m0;
    do_op(1'b1, 12'h400, 32'hCAFEF00D);
    m0 = miss_count;
    do_op(1'b0, 12'h400, '0);
    compared++;
    if (bus.cpu_rdata !== 32'hCAFEF00D || miss_count !== m0 + 16'd1) begin
      mismatched++; $display("FAIL write_no_allocate: got rdata=%h miss=%0d want cafef00d/%0d", bus.cpu_rdata, miss_count, m0 + 16'd1);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_a, exp_b;
    int n0;
    do_op(1'b0, 12'h010, '0);
    do_op(1'b0, 12'h011, '0);
    exp_a = ref_data[8][0];
    exp_b = ref_data[8][1];
    n0 = strobes.size();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h010;
    @(posedge clk); #1;
    bus.cpu_addr = 12'h011;
    @(negedge clk);
    compared++;
    if (bus.cpu_valid !== 1'b1 || bus.cpu_rdata !== exp_a) begin
      mismatched++; $display("FAIL b2b_first: got valid=%b rdata=%h want 1/%h", bus.cpu_valid, bus.cpu_rdata, exp_a);
    end
    @(negedge clk);
    compared++;
    if (bus.cpu_valid !== 1'b0 || bus.cpu_ready !== 1'b1) begin
      mismatched++; $display("FAIL b2b_gap: got valid=%b ready=%b want 0/1", bus.cpu_valid, bus.cpu_ready);
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.cpu_valid !== 1'b1 || bus.cpu_rdata !== exp_b) begin
      mismatched++; $display("FAIL b2b_second: got valid=%b rdata=%h want 1/%h", bus.cpu_valid, bus.cpu_rdata, exp_b);
    end
    ref_hits = sat_inc(sat_inc(ref_hits));
    ref_rdata = exp_b;
    @(negedge clk);
    compared++;
    if (hit_count !== ref_hits || strobes.size() != n0) begin
      mismatched++; $display("FAIL b2b_stats: got hit=%0d strobes=%0d want %0d/0", hit_count, strobes.size() - n0, ref_hits);
    end
  endtask

  task automatic test_conflict();
    apply_reset();
    do_op(1'b0, 12'h010, '0);
    do_op(1'b0, 12'h030, '0);
    do_op(1'b0, 12'h010, '0);
    compared++;
    if (miss_count !== 16'd3 || hit_count !== 16'd0) begin
      mismatched++; $display("FAIL conflict_counts: got miss=%0d hit=%0d want 3/0", miss_count, hit_count);
    end
  endtask

  task automatic test_reset_mid_op();
    int spurious;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h0A0;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.mem_read_en !== 1'b1) begin
      mismatched++; $display("FAIL abort_fill0_strobe: got %b want 1", bus.mem_read_en);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    compared++;
    if (bus.mem_read_en !== 1'b0 || bus.mem_write_en !== 1'b0 || bus.cpu_ready !== 1'b1 || bus.cpu_valid !== 1'b0) begin
      mismatched++; $display("FAIL abort_async: got rd=%b wr=%b ready=%b valid=%b want 0/0/1/0",
                             bus.mem_read_en, bus.mem_write_en, bus.cpu_ready, bus.cpu_valid);
    end
    ref_clear();
    @(negedge clk);
    rst = 1'b1;
    spurious = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.cpu_valid !== 1'b0) spurious++;
    end
    compared++;
    if (spurious != 0 || bus.cpu_ready !== 1'b1) begin
      mismatched++; $display("FAIL abort_no_valid: got %0d pulses ready=%b want 0/1", spurious, bus.cpu_ready);
    end
    do_op(1'b0, 12'h0A0, '0);
  endtask

  task automatic test_random();
    logic [6:0] tags [3];
    logic [AW-1:0] a;
    tags[0] = 7'h00; tags[1] = 7'h01; tags[2] = 7'h7F;
    for (int i = 0; i < 80; i++) begin
      a = {tags[$urandom_range(0, 2)], 4'($urandom), 1'($urandom)};
      do_op(($urandom_range(0, 2) == 0), a, $urandom);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    ref_clear();
    preload_all();
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_write_no_allocate();
    test_back_to_back();
    test_conflict();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
